// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg: state encoding, default timer constants and sizing helper
// shared by the PCI bus arbiter and its priority picker.
package pci_arb_pkg;
    localparam int DEF_N_MASTERS     = 4;
    localparam int DEF_LAT_TIMER     = 16;
    localparam int DEF_START_TIMEOUT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_BUSY,
        ST_DRAIN,
        ST_TURN
    } arb_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational find-first-set starting at i_ptr, wrapping
// modulo N; reports the winning index and whether any request is set.
module rr_priority_pick import pci_arb_pkg::*; #(
    parameter int N = DEF_N_MASTERS,
    parameter int W = clog2(DEF_N_MASTERS)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_winner,
    output logic         o_any
);
    logic [W-1:0] w_idx;

    // Walk from the farthest slot back to i_ptr so the nearest request wins.
    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = W'((int'(i_ptr) + i) % N);
            if (i_req[w_idx]) o_winner = w_idx;
        end
    end

    assign o_any = |i_req;
endmodule

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin arbiter for the shared PCI-style bus with a
// latency timer, a start timeout and a forced idle turnaround between owners.
module pci_bus_arbiter import pci_arb_pkg::*; #(
    parameter int N_MASTERS     = DEF_N_MASTERS,
    parameter int LAT_TIMER     = DEF_LAT_TIMER,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_MASTERS-1:0]        req,
    input  logic                        frame_n,
    input  logic                        irdy_n,
    output logic [N_MASTERS-1:0]        gnt,
    output logic [clog2(N_MASTERS)-1:0] owner,
    output logic                        owner_vld
);
    localparam int OW   = clog2(N_MASTERS);
    localparam int TMAX = (LAT_TIMER > START_TIMEOUT) ? LAT_TIMER : START_TIMEOUT;
    localparam int TW   = clog2(TMAX) + 1;
    localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);

    arb_state_e           r_state, w_next;
    logic [TW-1:0]        r_tmr, w_tmr;
    logic [OW-1:0]        r_ptr, r_owner, w_win;
    logic [N_MASTERS-1:0] r_gnt;
    logic                 w_any, w_grant, w_bus_idle, w_other, w_hold;

    rr_priority_pick #(.N(N_MASTERS), .W(OW)) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    assign w_bus_idle = frame_n & irdy_n;
    assign w_other    = |(req & ~(ONE << r_owner));
    assign w_hold     = (w_next == ST_GRANTED) || (w_next == ST_BUSY);

    // A dropped owner request wins over timer expiry, so a release in the
    // expiry cycle is handled as voluntary.
    always_comb begin
        w_next  = r_state;
        w_tmr   = '0;
        w_grant = 1'b0;
        case (r_state)
            ST_IDLE:
                if (w_any && w_bus_idle) begin
                    w_next  = ST_GRANTED;
                    w_grant = 1'b1;
                end
            ST_GRANTED:
                if (!frame_n) w_next = ST_BUSY;
                else if (!req[r_owner] || r_tmr == TW'(START_TIMEOUT - 1)) w_next = ST_TURN;
                else w_tmr = r_tmr + 1'b1;
            ST_BUSY:
                if (!req[r_owner] || (w_other && r_tmr == TW'(LAT_TIMER - 1))) w_next = ST_DRAIN;
                else if (w_other) w_tmr = r_tmr + 1'b1;
            ST_DRAIN:
                if (w_bus_idle) w_next = ST_TURN;
            default:
                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_next;
            r_tmr   <= w_tmr;
            if (w_grant) begin
                r_owner <= w_win;
                r_ptr   <= (int'(w_win) == N_MASTERS - 1) ? '0 : w_win + 1'b1;
                r_gnt   <= ONE << w_win;
            end else if (!w_hold) begin
                r_gnt <= '0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign owner     = r_owner;
    assign owner_vld = |r_gnt;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed self-checking bench for pci_bus_arbiter
// (N=4, LAT_TIMER=16, START_TIMEOUT=8); inputs change 1 time unit after posedge.
module tb_pci_bus_arbiter;
    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       owner_vld;
    int         n_chk;
    int         n_err;
    int         zeros;

    pci_bus_arbiter #(.N_MASTERS(4), .LAT_TIMER(16), .START_TIMEOUT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .frame_n   (frame_n),
        .irdy_n    (irdy_n),
        .gnt       (gnt),
        .owner     (owner),
        .owner_vld (owner_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output int z);
        z = 0;
        tick(1);
        while (gnt == 4'b0000 && z < 20) begin
            z++;
            tick(1);
        end
        chk("gnt_arrive", 32'(|gnt), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        req     = 4'b0000;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        reset_n = 1'b0;
        tick(2);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_owner", owner, 2'd0);
        chk("rst_vld", owner_vld, 1'b0);
        reset_n = 1'b1;
        tick(1);

        // 8085 handshake: grant one edge after reqP, released on next edge
        req = 4'b0001;
        tick(1);
        chk("h_gnt", gnt, 4'b0001);
        chk("h_vld", owner_vld, 1'b1);
        req = 4'b0000;
        tick(1);
        chk("h_turn", gnt, 4'b0000);
        tick(1);
        chk("h_idle", gnt, 4'b0000);
        chk("h_owner_hold", owner, 2'd0);
        chk("h_vld_low", owner_vld, 1'b0);

        // Reset mid-BUSY drops grant without a clock edge
        req = 4'b0010;
        tick(1);
        chk("r_gnt1", gnt, 4'b0010);
        frame_n = 1'b0;
        tick(1);
        chk("r_busy", gnt, 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_async_gnt", gnt, 4'b0000);
        chk("r_async_owner", owner, 2'd0);
        chk("r_async_vld", owner_vld, 1'b0);
        req     = 4'b0000;
        frame_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);
        chk("r_edge1", gnt, 4'b0000);
        req = 4'b0001;
        tick(1);
        chk("r_edge2", gnt, 4'b0001);
        req = 4'b0000;
        tick(2);

        // Round robin with all four requesting
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            int k;
            k = r % 4;
            wait_gnt(zeros);
            chk("rr_gnt", gnt, 32'(1 << k));
            chk("rr_owner", owner, 32'(k));
            if (r > 0) chk("rr_gap_after_drain", zeros, 32'd2);
            frame_n = 1'b0;
            tick(2);
            frame_n = 1'b1;
            req[k]  = 1'b0;
            tick(1);
            chk("rr_drop", gnt, 4'b0000);
            req[k] = 1'b1;
        end
        req = 4'b0000;
        tick(3);

        // Preemption after 16 cycles of a competing request
        req = 4'b0010;
        tick(1);
        chk("p_gnt", gnt, 4'b0010);
        frame_n = 1'b0;
        tick(1);
        req = 4'b0110;
        tick(15);
        chk("p_hold15", gnt, 4'b0010);
        tick(1);
        chk("p_drop16", gnt, 4'b0000);
        tick(3);
        chk("p_drain_wait", gnt, 4'b0000);
        frame_n = 1'b1;
        tick(1);
        chk("p_turn", gnt, 4'b0000);
        tick(1);
        chk("p_idle", gnt, 4'b0000);
        tick(1);
        chk("p_next", gnt, 4'b0100);
        chk("p_next_owner", owner, 2'd2);
        req = 4'b0000;
        tick(2);

        // Start timeout: grant revoked after 8 cycles without FRAME#
        req = 4'b1000;
        tick(1);
        chk("t_gnt", gnt, 4'b1000);
        req = 4'b1001;
        tick(7);
        chk("t_hold7", gnt, 4'b1000);
        tick(1);
        chk("t_revoke8", gnt, 4'b0000);
        tick(1);
        chk("t_idle", gnt, 4'b0000);
        tick(1);
        chk("t_next", gnt, 4'b0001);
        req = 4'b0000;
        tick(2);

        // Foreign traffic on the bus blocks granting
        frame_n = 1'b0;
        req     = 4'b0010;
        tick(3);
        chk("b_frame_low", gnt, 4'b0000);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        tick(1);
        chk("b_irdy_low", gnt, 4'b0000);
        irdy_n = 1'b1;
        tick(1);
        chk("b_gnt", gnt, 4'b0010);
        chk("b_owner", owner, 2'd1);
        req = 4'b0000;
        tick(2);
        chk("b_owner_hold", owner, 2'd1);
        chk("b_vld_low", owner_vld, 1'b0);

        // Request glitch between edges is never sampled
        req = 4'b1000;
        #3;
        req = 4'b0000;
        tick(1);
        chk("g_glitch", gnt, 4'b0000);
        tick(1);
        chk("g_glitch2", gnt, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
